lsu: RTL

- Memory-access stage of the core, directly upstream of the writeback mux.
- Takes the ALU-computed effective address, store data and load/store control from execute.
- Runs a request/acknowledge transaction on the data bus, with byte-lane steering and sign/zero extension.
- Presents the load result on mem_o, which feeds the writeback MEM input. Stalls the pipeline while a transaction is outstanding.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_align.sv | 84 ++++++++
 rtl/lsu.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   MEM_BUS      width of the load result handed to writeback
//   REG_BUS      architectural register width (store data, addresses)
//   DBUS_BE_BUS  number of byte enables on the data bus
//   LSU_*        RV32I funct3 encodings for load/store size and signedness
//   lsu_state_e  transaction FSM states
package lsu_pkg;

    localparam int MEM_BUS     = 32;
    localparam int REG_BUS     = 32;
    localparam int DBUS_BE_BUS = 4;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling for the load/store unit.
//   Request side (live execute inputs):
//     mem_we, funct3, addr_lo, wdata -> illegal, misaligned, be, st_data
//   Response side (fields latched at request time):
//     ld_funct3, ld_off, rdata -> ld_data (lane-selected and extended)
module lsu_align
    import lsu_pkg::*;
(
    input  logic                   mem_we,
    input  logic [2:0]             funct3,
    input  logic [1:0]             addr_lo,
    input  logic [REG_BUS-1:0]     wdata,
    input  logic [2:0]             ld_funct3,
    input  logic [1:0]             ld_off,
    input  logic [REG_BUS-1:0]     rdata,
    output logic                   illegal,
    output logic                   misaligned,
    output logic [DBUS_BE_BUS-1:0] be,
    output logic [REG_BUS-1:0]     st_data,
    output logic [MEM_BUS-1:0]     ld_data
);

    logic [REG_BUS-1:0] lane;

    // Unsigned variants only exist for loads.
    always_comb begin
        illegal = 1'b1;
        case (funct3)
            LSU_B, LSU_H, LSU_W: illegal = 1'b0;
            LSU_BU, LSU_HU:      illegal = mem_we;
            default:             illegal = 1'b1;
        endcase
    end

    // funct3[1:0] carries the access size: 00 byte, 01 half, 10 word.
    always_comb begin
        misaligned = 1'b0;
        be         = '0;
        case (funct3[1:0])
            2'b00: begin
                be = 4'b0001 << addr_lo;
            end
            2'b01: begin
                misaligned = addr_lo[0];
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                misaligned = |addr_lo;
                be         = 4'b1111;
            end
            default: begin
                misaligned = 1'b0;
                be         = '0;
            end
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone
    // pick the destination bytes.
    genvar gi;
    generate
        for (gi = 0; gi < DBUS_BE_BUS; gi++) begin : g_lane
            assign st_data[gi*8 +: 8] =
                (funct3[1:0] == 2'b00) ? wdata[7:0] :
                (funct3[1:0] == 2'b01) ? wdata[(gi % 2)*8 +: 8] :
                                         wdata[gi*8 +: 8];
        end
    endgenerate

    // Bring the addressed lane down to bit 0, then extend.
    assign lane = rdata >> {ld_off, 3'b000};

    always_comb begin
        ld_data = lane;
        case (ld_funct3)
            LSU_B:   ld_data = {{24{lane[7]}}, lane[7:0]};
            LSU_BU:  ld_data = {24'b0, lane[7:0]};
            LSU_H:   ld_data = {{16{lane[15]}}, lane[15:0]};
            LSU_HU:  ld_data = {16'b0, lane[15:0]};
            default: ld_data = lane;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Memory-access stage: runs one request/acknowledge data-bus transaction
// per load/store and returns the extended load result to writeback.
//   clk, rst                          clock, asynchronous active-high reset
//   mem_en_i, mem_we_i, funct3_i,
//   addr_i, wdata_i                   access from execute
//   dbus_req_o/we_o/addr_o/be_o/
//   wdata_o                           registered bus request fields
//   dbus_ack_i, dbus_rdata_i          bus completion and read data
//   mem_o                             extended load data (registered)
//   stall_o                           hold the upstream pipeline
//   done_o                            one-cycle completion pulse (RESP)
//   misalign_o                        misaligned access rejected (IDLE)
//   fault_o                           illegal funct3 (IDLE) or timeout (RESP)
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_en_i,
    input  logic                   mem_we_i,
    input  logic [2:0]             funct3_i,
    input  logic [REG_BUS-1:0]     addr_i,
    input  logic [REG_BUS-1:0]     wdata_i,
    output logic                   dbus_req_o,
    output logic                   dbus_we_o,
    output logic [REG_BUS-1:0]     dbus_addr_o,
    output logic [DBUS_BE_BUS-1:0] dbus_be_o,
    output logic [REG_BUS-1:0]     dbus_wdata_o,
    input  logic                   dbus_ack_i,
    input  logic [REG_BUS-1:0]     dbus_rdata_i,
    output logic [MEM_BUS-1:0]     mem_o,
    output logic                   stall_o,
    output logic                   done_o,
    output logic                   misalign_o,
    output logic                   fault_o
);

    // Counter value seen on the last BUSY cycle before expiry.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e               state_reg, state_next;
    logic [7:0]               cnt_reg;
    logic [2:0]               f3_reg;
    logic [1:0]               off_reg;
    logic                     tmo_reg;

    logic                     illegal;
    logic                     misaligned;
    logic [DBUS_BE_BUS-1:0]   be_w;
    logic [REG_BUS-1:0]       st_data_w;
    logic [MEM_BUS-1:0]       ld_data_w;
    logic                     launch;
    logic                     ack_busy;
    logic                     expire;

    lsu_align u_align (
        .mem_we     (mem_we_i),
        .funct3     (funct3_i),
        .addr_lo    (addr_i[1:0]),
        .wdata      (wdata_i),
        .ld_funct3  (f3_reg),
        .ld_off     (off_reg),
        .rdata      (dbus_rdata_i),
        .illegal    (illegal),
        .misaligned (misaligned),
        .be         (be_w),
        .st_data    (st_data_w),
        .ld_data    (ld_data_w)
    );

    assign launch   = (state_reg == LSU_IDLE) && mem_en_i && !illegal && !misaligned;
    assign ack_busy = (state_reg == LSU_BUSY) && dbus_ack_i;
    // An ack on the expiry cycle takes priority, hence the !dbus_ack_i.
    assign expire   = (state_reg == LSU_BUSY) && !dbus_ack_i && (cnt_reg == TMO_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LSU_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LSU_IDLE: if (launch) state_next = LSU_BUSY;
            LSU_BUSY: if (ack_busy || expire) state_next = LSU_RESP;
            LSU_RESP: state_next = LSU_IDLE;
            default:  state_next = LSU_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        misalign_o = 1'b0;
        fault_o    = 1'b0;
        stall_o    = 1'b0;
        done_o     = 1'b0;
        case (state_reg)
            LSU_IDLE: begin
                if (mem_en_i) begin
                    fault_o    = illegal;
                    misalign_o = !illegal && misaligned;
                    stall_o    = launch;
                end
            end
            LSU_BUSY: stall_o = 1'b1;
            LSU_RESP: begin
                done_o  = 1'b1;
                fault_o = tmo_reg;
            end
            default: ;
        endcase
    end

    // Bus fields, timeout counter and load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= '0;
            dbus_be_o    <= '0;
            dbus_wdata_o <= '0;
            mem_o        <= '0;
            cnt_reg      <= '0;
            f3_reg       <= '0;
            off_reg      <= '0;
            tmo_reg      <= 1'b0;
        end else begin
            case (state_reg)
                LSU_IDLE: begin
                    if (launch) begin
                        dbus_req_o   <= 1'b1;
                        dbus_we_o    <= mem_we_i;
                        dbus_addr_o  <= {addr_i[31:2], 2'b00};
                        dbus_be_o    <= be_w;
                        dbus_wdata_o <= st_data_w;
                        f3_reg       <= funct3_i;
                        off_reg      <= addr_i[1:0];
                        cnt_reg      <= '0;
                        tmo_reg      <= 1'b0;
                    end
                end
                LSU_BUSY: begin
                    if (dbus_ack_i) begin
                        dbus_req_o <= 1'b0;
                        if (!dbus_we_o) begin
                            mem_o <= ld_data_w;
                        end
                    end else if (expire) begin
                        dbus_req_o <= 1'b0;
                        tmo_reg    <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                LSU_RESP: tmo_reg <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
